// File: rtl/pitch_arb_pkg.sv
// Shared widths and FSM state encoding for the pitch lookup arbiter.
package pitch_arb_pkg;

  localparam int unsigned PITCH_W = 6;
  localparam int unsigned PHASE_W = 32;
  localparam int unsigned WCNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pitch_lookup_arbiter_rr_pick.sv
// Round-robin pick: lowest requesting voice at or after ptr, wrapping,
// found by priority-encoding a double-width request vector masked below ptr.
module rr_pick #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VOICE_W    = 2
) (
  input  logic [NUM_VOICES-1:0] req,
  input  logic [VOICE_W-1:0]    ptr,
  output logic [VOICE_W-1:0]    grant_c,
  output logic                  any_c
);

  localparam int unsigned DBL_W = 2 * NUM_VOICES;
  localparam int unsigned IDX_W = VOICE_W + 1;

  logic [DBL_W-1:0] dbl;
  logic [DBL_W-1:0] masked;
  logic [IDX_W-1:0] idx;

  always_comb begin
    dbl    = {req, req};
    masked = dbl & ~((DBL_W'(1) << ptr) - DBL_W'(1));
    idx    = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = DBL_W - 1; i >= 0; i--) begin
      if (masked[i]) idx = IDX_W'(i);
    end
    any_c = |req;
    if (idx >= IDX_W'(NUM_VOICES)) grant_c = VOICE_W'(idx - IDX_W'(NUM_VOICES));
    else                           grant_c = VOICE_W'(idx);
  end

endmodule

// File: rtl/pitch_lookup_arbiter.sv
// Round-robin arbiter sharing one pitch_lookup instance among NUM_VOICES voices.
// Optional WAIT-state timeout is enabled by defining PITCH_ARB_TIMEOUT_EN.
module pitch_lookup_arbiter
  import pitch_arb_pkg::*;
#(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned VOICE_W        = $clog2(NUM_VOICES),
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_VOICES-1:0]         i_req,
  input  logic [PITCH_W*NUM_VOICES-1:0] i_pitch,
  output logic [NUM_VOICES-1:0]         o_ack,
  output logic [VOICE_W-1:0]            o_ack_voice,
  output logic [PHASE_W-1:0]            o_phase_delta,
  output logic                          o_err,
  output logic                          o_lu_enable,
  output logic [PITCH_W-1:0]            o_lu_pitch,
  input  logic                          i_lu_valid,
  input  logic [PHASE_W-1:0]            i_lu_phase_delta
);

  if (NUM_VOICES < 2 || NUM_VOICES > 8 ||
      TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= (1 << WCNT_W)) begin : g_param_check
    $error("pitch_lookup_arbiter: parameter out of range");
  end

  arb_state_t         state;
  logic [VOICE_W-1:0] rr_ptr;
  logic [VOICE_W-1:0] gnt;
  logic [VOICE_W-1:0] pick_c;
  logic               pick_any_c;

  rr_pick #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W)
  ) u_rr_pick (
    .req     (i_req),
    .ptr     (rr_ptr),
    .grant_c (pick_c),
    .any_c   (pick_any_c)
  );

`ifdef PITCH_ARB_TIMEOUT_EN
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
  logic [WCNT_W-1:0] wait_cnt;
`endif

  // FSM, grant/pitch latches and registered outputs; o_lu_pitch doubles as the pitch latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      gnt           <= '0;
      o_ack         <= '0;
      o_ack_voice   <= '0;
      o_phase_delta <= '0;
      o_err         <= 1'b0;
      o_lu_enable   <= 1'b0;
      o_lu_pitch    <= '0;
`ifdef PITCH_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      o_ack       <= '0;
      o_lu_enable <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_any_c) begin
            gnt         <= pick_c;
            o_lu_pitch  <= i_pitch[PITCH_W*pick_c +: PITCH_W];
            o_lu_enable <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef PITCH_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (i_lu_valid) begin
            o_ack         <= NUM_VOICES'(1) << gnt;
            o_ack_voice   <= gnt;
            o_phase_delta <= i_lu_phase_delta;
            state         <= S_ACK;
          end
`ifdef PITCH_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            o_ack         <= NUM_VOICES'(1) << gnt;
            o_ack_voice   <= gnt;
            o_phase_delta <= '0;
            o_err         <= 1'b1;
            state         <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
`endif
        end
        S_ACK: begin
          rr_ptr <= (gnt == VOICE_W'(NUM_VOICES - 1)) ? '0 : gnt + VOICE_W'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_lookup_arbiter.sv
// Scoreboard bench for pitch_lookup_arbiter with a behavioural pitch_lookup model.
module tb_pitch_lookup_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned VW  = 2;
  localparam int unsigned L   = 4;
  localparam int unsigned TMO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [6*N-1:0]  pitch;
  logic [N-1:0]    ack;
  logic [VW-1:0]   ack_voice;
  logic [31:0]     phase;
  logic            err;
  logic            lu_en;
  logic [5:0]      lu_pitch;
  logic            lu_valid;
  logic [31:0]     lu_data;
  logic            model_valid = 1'b0;
  logic [31:0]     model_data  = '0;
  logic            spur_valid  = 1'b0;
  logic [31:0]     spur_data   = '0;

  assign lu_valid = model_valid | spur_valid;
  assign lu_data  = spur_valid ? spur_data : model_data;

  always #5 clk = ~clk;

  pitch_lookup_arbiter #(
    .NUM_VOICES     (N),
    .VOICE_W        (VW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req            (req),
    .i_pitch          (pitch),
    .o_ack            (ack),
    .o_ack_voice      (ack_voice),
    .o_phase_delta    (phase),
    .o_err            (err),
    .o_lu_enable      (lu_en),
    .o_lu_pitch       (lu_pitch),
    .i_lu_valid       (lu_valid),
    .i_lu_phase_delta (lu_data)
  );

  typedef struct {
    int          voice;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lut [64];
  exp_t        sb [$];
  int          ack_log [$];
  int          cyc = 0;
  int          ptr_m = 0;
  bit          inflight = 0;
  int          inflight_v = 0;
  logic [5:0]  inflight_p = '0;
  bit          lu_mute = 0;
  bit          hold_all = 0;
  bit          rand_mode = 0;
  bit          scramble = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Lookup model: result lut[pitch] pulses L cycles after the enable is sampled.
  int         lu_cnt = 0;
  logic [5:0] lu_hold = '0;
  always @(posedge clk) begin
    #1;
    model_valid = 1'b0;
    if (rst) lu_cnt = 0;
    else begin
      if (lu_cnt > 0) begin
        lu_cnt--;
        if (lu_cnt == 0) begin
          model_valid = 1'b1;
          model_data  = lut[lu_hold];
        end
      end
      if (lu_en && !lu_mute) begin
        lu_cnt  = L;
        lu_hold = lu_pitch;
      end
    end
  end

  // Monitor: predicts each grant from the rotation rule, then pops on every ack.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      ptr_m    = 0;
      inflight = 0;
    end else begin
      chk("ack_en_exclusive", 64'(ack != 0 && lu_en), 64'd0);
      if (lu_en) begin
        int g;
        logic [5:0] p;
        g = -1;
        for (int k = 0; k < int'(N); k++)
          if (g < 0 && req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        if (g < 0) fail("grant_without_req");
        else begin
          p = pitch[6*g +: 6];
          chk("lu_pitch", 64'(lu_pitch), 64'(p));
          e.voice = g;
          e.data  = lu_mute ? 32'd0 : lut[p];
          e.err   = lu_mute;
          e.cyc   = cyc + (lu_mute ? int'(TMO) + 1 : int'(L) + 1);
          sb.push_back(e);
          ptr_m      = (g + 1) % N;
          inflight   = 1;
          inflight_v = g;
          inflight_p = p;
        end
      end else if (inflight && ack == 0) begin
        chk("lu_pitch_hold", 64'(lu_pitch), 64'(inflight_p));
      end
      if (ack != 0) begin
        if (sb.size() == 0) fail("unexpected_ack");
        else begin
          e = sb.pop_front();
          chk("ack_onehot", 64'(ack), 64'(1) << e.voice);
          chk("ack_voice", 64'(ack_voice), 64'(e.voice));
          chk("phase_delta", 64'(phase), 64'(e.data));
          chk("err", 64'(err), 64'(e.err));
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          ack_log.push_back(e.voice);
          inflight = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (!hold_all) req = req & ~ack;
    if (scramble && inflight) pitch[6*inflight_v +: 6] = 6'($urandom);
    if (rand_mode)
      for (int k = 0; k < int'(N); k++)
        if (!req[k] && !ack[k] && $urandom_range(3) == 0) begin
          req[k] = 1'b1;
          pitch[6*k +: 6] = 6'($urandom);
        end
  endtask

  task automatic run_until_quiet(input string name, input int budget);
    int n = 0;
    while (!(req == 0 && sb.size() == 0 && !inflight) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail({name, "_quiet_timeout"});
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ack"}, 64'(ack), 64'd0);
    chk({name, "_ack_voice"}, 64'(ack_voice), 64'd0);
    chk({name, "_phase"}, 64'(phase), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
    chk({name, "_lu_en"}, 64'(lu_en), 64'd0);
    chk({name, "_lu_pitch"}, 64'(lu_pitch), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int t2_exp [6] = '{0, 1, 2, 3, 0, 1};
    int t3_exp [3] = '{3, 0, 1};

    rst   = 1'b1;
    req   = '0;
    pitch = '0;
    for (int i = 0; i < 64; i++) lut[i] = $urandom;
    lut[12] = 32'h0001_2345;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single request, fixed latency
    tick();
    req = 4'b0100;
    pitch[17:12] = 6'd12;
    tick();
    chk("t1_enable_cycle1", 64'(lu_en), 64'd1);
    chk("t1_lu_pitch", 64'(lu_pitch), 64'd12);
    repeat (5) tick();
    chk("t1_ack", 64'(ack), 64'b0100);
    chk("t1_ack_voice", 64'(ack_voice), 64'd2);
    chk("t1_phase", 64'(phase), 64'h0001_2345);
    run_until_quiet("t1", 40);

    // All voices held: rotation from voice 0 after reset
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = ack_log.size();
    hold_all = 1;
    pitch = {6'd60, 6'd33, 6'd17, 6'd5};
    req = 4'b1111;
    n = 0;
    while (ack_log.size() < base + 6 && n < 200) begin
      tick();
      n++;
    end
    req = '0;
    hold_all = 0;
    run_until_quiet("t2", 40);
    if (ack_log.size() < base + 6) fail("t2_ack_count");
    else for (int i = 0; i < 6; i++) chk("t2_order", 64'(ack_log[base + i]), 64'(t2_exp[i]));

    // Pointer at 2 after v1: 1011 -> v3, v0, v1
    base = ack_log.size();
    pitch = {6'd7, 6'd40, 6'd22, 6'd63};
    req = 4'b1011;
    run_until_quiet("t3", 100);
    if (ack_log.size() != base + 3) fail("t3_ack_count");
    else for (int i = 0; i < 3; i++) chk("t3_order", 64'(ack_log[base + i]), 64'(t3_exp[i]));

    // Reset during WAIT: no ack, pointer back to 0
    req = 4'b0100;
    pitch[17:12] = 6'd31;
    n = 0;
    while (!lu_en && n < 10) begin
      tick();
      n++;
    end
    if (!lu_en) fail("t4_no_enable");
    repeat (2) tick();
    rst = 1'b1;
    req = '0;
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_no_ack", 64'(ack), 64'd0);
    end
    base = ack_log.size();
    pitch = {6'd1, 6'd2, 6'd44, 6'd3};
    req = 4'b0110;
    tick();
    run_until_quiet("t4", 60);
    if (ack_log.size() < base + 1) fail("t4_ack_count");
    else chk("t4_first_voice", 64'(ack_log[base]), 64'd1);

    // Spurious valid in IDLE is ignored
    spur_data  = 32'hdead_beef;
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_ack", 64'(ack), 64'd0);
      chk("t5_no_enable", 64'(lu_en), 64'd0);
    end
    pitch[5:0] = 6'd9;
    req = 4'b0001;
    tick();
    chk("t5_idle_grant", 64'(lu_en), 64'd1);
    run_until_quiet("t5", 40);

`ifdef PITCH_ARB_TIMEOUT_EN
    // Lookup never answers: timeout ack with err, then normal service
    lu_mute = 1;
    pitch[23:18] = 6'd50;
    req = 4'b1000;
    run_until_quiet("t6_timeout", 60);
    lu_mute = 0;
    base = ack_log.size();
    pitch[5:0] = 6'd21;
    req = 4'b0001;
    run_until_quiet("t6_next", 40);
    chk("t6_next_served", 64'(ack_log.size()), 64'(base + 1));
`endif

    // Randomised traffic with in-flight pitch scrambling
    base = ack_log.size();
    rand_mode = 1;
    scramble  = 1;
    repeat (1500) tick();
    rand_mode = 0;
    run_until_quiet("random", 200);
    scramble = 0;
    chk("random_acks_seen", 64'(ack_log.size() > base + 50), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
